// File: rtl/serial_frame_deser.sv
// -----------------------------------------------------------------------------
// serial_frame_deser
// Receive-side deserializer for the IO serializer loopback. Hunts for SYNC_WORD
// in the enabled serial stream to find word boundaries, then assembles aligned
// words (MSB first) into a small FIFO drained through a valid/ready handshake.
//
// Ports
//   clk_i       : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   data_i      : serial bit, sampled only when enable=1
//   enable      : qualifies data_i
//   hunt_i      : force re-alignment (back to HUNT)
//   data_o      : FIFO head word (holds last value when empty)
//   valid_o     : data_o holds a word
//   ready_i     : consumer accepts data_o
//   locked_o    : word alignment established
//   overflow_o  : sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module serial_frame_deser #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
  parameter int unsigned      DEPTH     = 4
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             data_i,
  input  logic             enable,
  input  logic             hunt_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             locked_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Alignment state
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] sr_shift;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic             push;

  // FIFO state
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [FCNT_W-1:0] fifo_cnt_nxt;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic [WIDTH-1:0]  data_nxt;
  logic              valid_nxt;
  logic              overflow_nxt;

  // Value the shift register takes on an enabled edge
  assign sr_shift = {sr[WIDTH-2:0], data_i};

  // Alignment FSM: next state, bit counter and word-complete push request
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    push        = 1'b0;

    if (enable) begin
      sr_nxt = sr_shift;
      case (state)
        ST_HUNT: begin
          if (sr_shift == SYNC_WORD) begin
            state_nxt   = ST_LOCKED;
            bit_cnt_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            bit_cnt_nxt = '0;
            // An aligned sync word is a re-alignment marker, never data
            push        = (sr_shift != SYNC_WORD);
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt   = ST_HUNT;
          bit_cnt_nxt = '0;
        end
      endcase
    end

    // Re-hunt wins over a word completing on the same edge
    if (hunt_i) begin
      state_nxt   = ST_HUNT;
      bit_cnt_nxt = '0;
      push        = 1'b0;
    end
  end

  // Alignment FSM registers
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HUNT;
      sr       <= '0;
      bit_cnt  <= '0;
      locked_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      locked_o <= (state_nxt == ST_LOCKED);
    end
  end

  // FIFO control: a full FIFO still accepts a push when it pops on the same edge
  always_comb begin
    pop          = valid_o & ready_i;
    full         = (fifo_cnt == FCNT_W'(DEPTH));
    push_ok      = push & (~full | pop);
    fifo_cnt_nxt = fifo_cnt + FCNT_W'(push_ok) - FCNT_W'(pop);
    rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
    wr_ptr_nxt   = wr_ptr + PTR_W'(push_ok);
    overflow_nxt = overflow_o | (push & ~push_ok);
    valid_nxt    = (fifo_cnt_nxt != '0);

    // Registered head: the pushed word goes straight to data_o when nothing
    // older remains, otherwise the next stored entry is presented
    data_nxt = data_o;
    if (valid_nxt) begin
      if ((fifo_cnt - FCNT_W'(pop)) == '0) begin
        data_nxt = sr_shift;
      end else begin
        data_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // FIFO storage, no reset needed: entries are only read after being written
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= sr_shift;
    end
  end

  // FIFO pointers, occupancy and output registers
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_cnt   <= fifo_cnt_nxt;
      data_o     <= data_nxt;
      valid_o    <= valid_nxt;
      overflow_o <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_deser.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_deser
// Self-checking bench for serial_frame_deser. A behavioural model keeps the
// history of sampled bits, the sample index where alignment started and a
// word queue standing in for the FIFO; directed scenarios check fixed values
// and a randomized run compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_serial_frame_deser;

  localparam int unsigned      WIDTH = 8;
  localparam int unsigned      DEPTH = 4;
  localparam logic [WIDTH-1:0] SYNC  = 8'hA5;

  logic             clk_i = 1'b0;
  logic             reset_n;
  logic             data_i;
  logic             enable;
  logic             hunt_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             locked_o;
  logic             overflow_o;

  int checks = 0;
  int errors = 0;

  // Model state
  int               hist[$];
  int               lock_pos;
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf;
  logic [WIDTH-1:0] m_head;
  logic [WIDTH-1:0] got[$];

  serial_frame_deser #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .data_i     (data_i),
    .enable     (enable),
    .hunt_i     (hunt_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .locked_o   (locked_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    hist.delete();
    lock_pos = -1;
    mq.delete();
    m_ovf    = 1'b0;
    m_head   = '0;
    got.delete();
  endtask

  // Last WIDTH sampled bits, oldest first; bits before reset count as 0
  function automatic logic [WIDTH-1:0] window();
    logic [WIDTH-1:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      idx = hist.size() - int'(WIDTH) + k;
      w[WIDTH-1-k] = (idx >= 0) ? hist[idx][0] : 1'b0;
    end
    return w;
  endfunction

  // Advance one clock: record any handshake, update the model, wait #1 past edge
  task automatic tick();
    bit               pop;
    bit               push;
    bit               ok;
    logic [WIDTH-1:0] w;
    if (valid_o === 1'b1 && ready_i === 1'b1) got.push_back(data_o);
    pop  = (mq.size() > 0) && ready_i;
    push = 1'b0;
    w    = '0;
    if (enable) begin
      hist.push_back(int'(data_i));
      w = window();
      if (!hunt_i) begin
        if (lock_pos < 0) begin
          if (w == SYNC) lock_pos = hist.size();
        end else if (((hist.size() - lock_pos) % int'(WIDTH)) == 0) begin
          push = (w != SYNC);
        end
      end
    end
    if (hunt_i) lock_pos = -1;
    ok = push && ((mq.size() < int'(DEPTH)) || pop);
    if (pop) void'(mq.pop_front());
    if (ok) mq.push_back(w);
    if (push && !ok) m_ovf = 1'b1;
    if (mq.size() > 0) m_head = mq[0];
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    data_i  = 1'b0;
    hunt_i  = 1'b0;
    ready_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    enable = 1'b1;
    hunt_i = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      data_i = w[i];
      tick();
    end
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (data_o !== '0 || valid_o !== 1'b0 || locked_o !== 1'b0 || overflow_o !== 1'b0)
      begin errors++; $display("FAIL reset_values: data=%h valid=%b locked=%b ovf=%b expected all 0", data_o, valid_o, locked_o, overflow_o); end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || locked_o !== 1'b0)
      begin errors++; $display("FAIL reset_idle: valid=%b locked=%b expected 0 0", valid_o, locked_o); end
  endtask

  task automatic test_lock_first_word();
    logic [15:0] s;
    s = 16'hA53C;
    do_reset();
    ready_i = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_i = s[15-i];
      tick();
      if (i == 6) begin
        checks++;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b expected 0", locked_o); end
      end
      if (i == 7) begin
        checks++;
        if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_rise: locked=%b expected 1", locked_o); end
      end
      if (i == 14) begin
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL word_early: valid=%b expected 0", valid_o); end
      end
    end
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h3C)
      begin errors++; $display("FAIL first_word: valid=%b data=%h expected 1 3c", valid_o, data_o); end
    enable = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b0)
      begin errors++; $display("FAIL word_pulse: valid=%b ovf=%b expected 0 0", valid_o, overflow_o); end
  endtask

  task automatic test_enable_gating();
    logic [15:0] s;
    int i;
    s = 16'hA53C;
    i = 0;
    do_reset();
    ready_i = 1'b1;
    for (int c = 0; c < 400 && i < 16; c++) begin
      enable = 1'($urandom % 2);
      if (enable) begin
        data_i = s[15-i];
        i++;
      end else begin
        data_i = 1'($urandom % 2);
      end
      tick();
    end
    enable = 1'b0;
    repeat (3) tick();
    checks++;
    if (got.size() != 1 || got[0] !== 8'h3C)
      begin errors++; $display("FAIL enable_gating: words=%0d first=%h expected 1 3c", got.size(), (got.size() > 0) ? got[0] : 8'h00); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(SYNC);
    for (int v = 1; v <= 5; v++) begin
      send_word(8'(v));
      if (v == 4) begin
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: ovf=%b expected 0", overflow_o); end
      end
    end
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h01 || overflow_o !== 1'b1)
      begin errors++; $display("FAIL ovf_set: valid=%b data=%h ovf=%b expected 1 01 1", valid_o, data_o, overflow_o); end
    ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (valid_o !== 1'b1 || data_o !== 8'(k))
        begin errors++; $display("FAIL ovf_drain%0d: valid=%b data=%h expected 1 %h", k, valid_o, data_o, 8'(k)); end
      tick();
    end
    checks++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b1)
      begin errors++; $display("FAIL ovf_empty: valid=%b ovf=%b expected 0 1", valid_o, overflow_o); end
  endtask

  task automatic test_full_with_pop();
    logic [WIDTH-1:0] w [5];
    for (int k = 0; k < 5; k++) begin
      w[k] = 8'($urandom_range(0, 255));
      if (w[k] == SYNC) w[k] = 8'h5A;
    end
    do_reset();
    send_word(SYNC);
    for (int k = 0; k < 4; k++) send_word(w[k]);
    enable = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      data_i  = w[4][i];
      ready_i = (i == 0);
      tick();
    end
    ready_i = 1'b0;
    enable  = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || valid_o !== 1'b1 || data_o !== w[1])
      begin errors++; $display("FAIL full_pop: ovf=%b valid=%b data=%h expected 0 1 %h", overflow_o, valid_o, data_o, w[1]); end
    ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (valid_o !== 1'b1 || data_o !== w[k])
        begin errors++; $display("FAIL full_drain%0d: valid=%b data=%h expected 1 %h", k, valid_o, data_o, w[k]); end
      tick();
    end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL full_count: valid=%b expected 0 after 4 pops", valid_o); end
  endtask

  task automatic test_realign();
    logic [WIDTH-1:0] s;
    s = SYNC;
    do_reset();
    ready_i = 1'b1;
    send_word(SYNC);
    enable = 1'b1;
    data_i = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    hunt_i = 1'b1;
    tick();
    hunt_i = 1'b0;
    checks++;
    if (locked_o !== 1'b0) begin errors++; $display("FAIL hunt_drop: locked=%b expected 0", locked_o); end
    enable = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      data_i = s[i];
      tick();
      checks++;
      if (locked_o !== (i == 0))
        begin errors++; $display("FAIL relock bit %0d: locked=%b expected %b", i, locked_o, (i == 0)); end
    end
    send_word(8'h77);
    send_word(SYNC);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL sync_in_lock: valid=%b expected 0", valid_o); end
    send_word(8'h33);
    repeat (2) tick();
    checks++;
    if (got.size() != 2 || got[0] !== 8'h77 || got[1] !== 8'h33)
      begin errors++; $display("FAIL realign_words: count=%0d expected 77 then 33", got.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(SYNC);
    send_word(8'h5C);
    enable = 1'b1;
    data_i = 1'b1; tick();
    data_i = 1'b0; tick();
    data_i = 1'b1; tick();
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre: valid=%b expected 1", valid_o); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_o !== '0 || valid_o !== 1'b0 || locked_o !== 1'b0 || overflow_o !== 1'b0)
      begin errors++; $display("FAIL mid_reset: data=%h valid=%b locked=%b ovf=%b expected all 0", data_o, valid_o, locked_o, overflow_o); end
    model_reset();
    enable = 1'b0;
    @(posedge clk_i);
    #1;
    reset_n = 1'b1;
    ready_i = 1'b1;
    send_word(8'h00);
    send_word(8'h00);
    checks++;
    if (valid_o !== 1'b0 || locked_o !== 1'b0 || got.size() != 0)
      begin errors++; $display("FAIL mid_no_word: valid=%b locked=%b words=%0d expected 0 0 0", valid_o, locked_o, got.size()); end
    send_word(SYNC);
    send_word(8'h6B);
    repeat (2) tick();
    checks++;
    if (got.size() != 1 || got[0] !== 8'h6B)
      begin errors++; $display("FAIL mid_relock: words=%0d expected one 6b", got.size()); end
  endtask

  task automatic test_random();
    int               bits[$];
    logic [WIDTH-1:0] w;
    logic             e_valid;
    logic             e_locked;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      w = (k == 0 || ($urandom % 4) == 0) ? SYNC : 8'($urandom_range(0, 255));
      for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(int'(w[i]));
    end
    for (int c = 0; c < 3000 && bits.size() > 0; c++) begin
      enable  = 1'(($urandom % 4) != 0);
      hunt_i  = 1'(($urandom % 80) == 0);
      ready_i = (c < 500) ? 1'(($urandom % 12) == 0) : 1'($urandom % 2);
      data_i  = enable ? 1'(bits.pop_front()) : 1'($urandom % 2);
      tick();
      e_valid  = (mq.size() > 0);
      e_locked = (lock_pos >= 0);
      checks++;
      if (valid_o !== e_valid || data_o !== m_head || locked_o !== e_locked || overflow_o !== m_ovf)
        begin errors++; $display("FAIL random cyc %0d: valid=%b data=%h locked=%b ovf=%b expected %b %h %b %b", c, valid_o, data_o, locked_o, overflow_o, e_valid, m_head, e_locked, m_ovf); end
    end
    checks++;
    if (bits.size() != 0) begin errors++; $display("FAIL random_budget: %0d bits left expected 0", bits.size()); end
  endtask

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;
    data_i  = 1'b0;
    hunt_i  = 1'b0;
    ready_i = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_lock_first_word();
    test_enable_gating();
    test_overflow();
    test_full_with_pop();
    test_realign();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_deser.md
# serial_frame_deser

Receive-side deserializer sitting directly downstream of the IO serializer test block: it consumes the 1-bit `data_o` stream (qualified by `enable`) and rebuilds parallel words. It hunts for a sync word to find word boundaries, then assembles aligned words into a small FIFO. The FIFO is drained through a valid/ready handshake. This lets the IO testcases close the loop serial-out → serial-in on the FPGA fabric.

## Interface
- `WIDTH`, 8: word width in bits (≥2).
- `SYNC_WORD`, 8'hA5: alignment pattern, `WIDTH` bits.
- `DEPTH`, 4: FIFO depth in words, power of two, ≥2.
- `clk_i`  input  1  single clock, rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `data_i`  input  1  serial bit, MSB of each word first.
- `enable`  input  1  `data_i` is sampled only on edges where `enable`=1.
- `hunt_i`  input  1  force re-alignment; returns to HUNT.
- `data_o`  output  WIDTH  FIFO head word.
- `valid_o`  output  1  `data_o` holds a word.
- `ready_i`  input  1  consumer accepts `data_o`.
- `locked_o`  output  1  word alignment established.
- `overflow_o`  output  1  sticky; a completed word was dropped.

## Operation
- Reset (asynchronous, `reset_n`=0): state=HUNT, shift register=0, bit counter=0, FIFO empty.
  - Reset values: `data_o`=0, `valid_o`=0, `locked_o`=0, `overflow_o`=0.
  - Asserting reset mid-word or mid-drain discards everything immediately.
- Shift register: on each edge with `enable`=1, `sr <= {sr[WIDTH-2:0], data_i}`.
- HUNT state:
  - When the value after the shift equals `SYNC_WORD`, go to LOCKED and clear the bit counter.
  - The sync word itself is not pushed.
- LOCKED state:
  - The bit counter increments on each enabled sample and wraps from WIDTH-1 to 0.
  - On the sample that wraps it, the completed word (`sr` after shift) is a candidate.
  - If the candidate equals `SYNC_WORD`, it is discarded (re-alignment marker, no push).
  - Otherwise it is pushed to the FIFO.
- `hunt_i`=1 on an edge:
  - state → HUNT and the bit counter clears; any partial word is discarded.
  - `hunt_i` has priority over a word completing on the same edge; that word is not pushed.
  - FIFO contents and `overflow_o` are kept.
  - The shift register keeps shifting, so a sync word can still be detected on a later edge.
- `locked_o` = (state==LOCKED), registered.
- FIFO rules:
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - A push that is not accepted drops the word and sets `overflow_o`, which stays set until reset.
  - Pop happens on an edge with `valid_o`=1 and `ready_i`=1.
  - Simultaneous push+pop leaves the count unchanged.
  - When empty, `data_o` holds its last value and `valid_o`=0.
  - Words leave in arrival order.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
- `ready_i` is ignored while `valid_o`=0.

## Timing
- All outputs are registered, with no combinational input→output path.
- Lock latency: `locked_o` rises at the edge that samples the last sync bit, so it is visible in the following cycle.
- Word latency:
  - A word completed at edge N, with the FIFO empty, gives `valid_o`=1 and `data_o`=word after edge N (visible in cycle N+1).
  - This is 1 cycle after the last bit is sampled.
- Throughput:
  - One pop per cycle.
  - Pushes arrive at most once every WIDTH enabled cycles, so with `ready_i`=1 held the FIFO never exceeds 1 entry.
- With `enable`=0, the shift register, counter and state are frozen; FIFO drain continues.
- `hunt_i` takes effect at the edge where it is sampled: `locked_o`=0 the next cycle.

## Test plan
- Lock and first word:
  - Stimulus: reset, then serial 0xA5 followed by 0x3C, `enable`=1, `ready_i`=1.
  - Response: `locked_o`=1 after the 8th bit edge; one-cycle `valid_o` pulse with `data_o`=0x3C after the 16th bit edge.
  - `overflow_o`=0 throughout.
- Enable gating:
  - Stimulus: same stream with `enable` toggling randomly, 50% duty.
  - Response: identical words, 0x3C; no extra or missing pushes.
- Backpressure/overflow:
  - Stimulus: lock, hold `ready_i`=0, send 0x01..0x05.
  - Response: `valid_o`=1 with `data_o`=0x01; `overflow_o`=1 after the 0x05 edge.
  - Then raise `ready_i`: drains 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then `valid_o`=0.
- Full-with-pop:
  - Stimulus: FIFO holds 4 words; `ready_i`=1 on exactly the edge where a 5th word completes.
  - Response: 5th word accepted, count stays 4, `overflow_o` unchanged at 0.
- Re-align:
  - Stimulus: in LOCKED, send 4 bits of 0xFF, assert `hunt_i` for one cycle, then send 0xA5, 0x77.
  - Response: `locked_o` drops for the intervening cycles; output is 0x77 only.
  - Also: an in-lock 0xA5 word produces no `valid_o`.
- Reset mid-operation:
  - Stimulus: pull `reset_n` low asynchronously (between edges) while `valid_o`=1 and 3 bits of a word are captured.
  - Response: all outputs 0 immediately.
  - After release, no word appears until a new 0xA5 is received.
